// File: rtl/gpa_fhdo_seq_pkg.sv
// Shared types and constants for the gpa_fhdo_seq update scheduler.
package gpa_fhdo_seq_pkg;

    localparam int unsigned CH_W       = 24;
    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned SAMPLE_W   = 4 * CH_W;

    typedef struct packed {
        logic [CH_W-1:0] x;
        logic [CH_W-1:0] y;
        logic [CH_W-1:0] z;
        logic [CH_W-1:0] z2;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_ZERO = 2'd3
    } state_e;

endpackage

// File: rtl/gpa_fhdo_seq_if.sv
// Sample-input bus and gpa_fhdo_iface-facing bus of the update scheduler.
interface gpa_fhdo_seq_if;
    import gpa_fhdo_seq_pkg::*;

    logic [CH_W-1:0] in_datax_i;
    logic [CH_W-1:0] in_datay_i;
    logic [CH_W-1:0] in_dataz_i;
    logic [CH_W-1:0] in_dataz2_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [CH_W-1:0] datax_o;
    logic [CH_W-1:0] datay_o;
    logic [CH_W-1:0] dataz_o;
    logic [CH_W-1:0] dataz2_o;
    logic            valid_o;
    logic            busy_i;

    modport slave (
        input  in_datax_i, in_datay_i, in_dataz_i, in_dataz2_i, in_valid_i, busy_i,
        output in_ready_o, datax_o, datay_o, dataz_o, dataz2_o, valid_o
    );

    modport master (
        output in_datax_i, in_datay_i, in_dataz_i, in_dataz2_i, in_valid_i, busy_i,
        input  in_ready_o, datax_o, datay_o, dataz_o, dataz2_o, valid_o
    );

endinterface

// File: rtl/gpa_fhdo_seq_fifo.sv
// Synchronous sample FIFO, depth 2^AW; clear dominates push and pop.
module gpa_fhdo_seq_fifo
    import gpa_fhdo_seq_pkg::*;
#(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  sample_t       din_i,
    output sample_t       head_c,
    output logic          empty_c,
    output logic          full_c,
    output logic [AW:0]   count_o
);

    localparam int unsigned DEPTH = 1 << AW;

    sample_t         mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_ok, pop_ok;

    always_comb begin
        full_c  = (count_q == (AW+1)'(DEPTH));
        empty_c = (count_q == '0);
        push_ok = push_i && !full_c && !clear_i;
        pop_ok  = pop_i && !empty_c;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

    assign head_c  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/gpa_fhdo_seq.sv
// Periodic update scheduler feeding gpa_fhdo_iface from a sample FIFO.
// Optional GPA_FHDO_SEQ_ZERO_ON_STOP_EN: stop drives one all-zero update before idling.
module gpa_fhdo_seq
    import gpa_fhdo_seq_pkg::*;
#(
    parameter int unsigned FIFO_AW  = 4,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    gpa_fhdo_seq_if.slave       bus,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                clear_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                running_o,
    output logic                underrun_o,
    output logic                late_o,
    output logic [FIFO_AW:0]    fifo_count_o
);

`ifdef GPA_FHDO_SEQ_ZERO_ON_STOP_EN
    localparam state_e STOP_ST = ST_ZERO;
`else
    localparam state_e STOP_ST = ST_IDLE;
`endif

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    sample_t             dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                running_q, running_d;
    logic                underrun_q, underrun_d;
    logic                late_q, late_d;

    sample_t             in_sample_c, head_c;
    logic                fifo_empty_c, fifo_full_c;
    logic                push_c, issue_c, tick_c;
    logic [PERIOD_W-1:0] reload_c, cnt_next_c;

    assign in_sample_c = {bus.in_datax_i, bus.in_datay_i, bus.in_dataz_i, bus.in_dataz2_i};
    assign bus.in_ready_o = !rst && !fifo_full_c;
    assign push_c = bus.in_valid_i && bus.in_ready_o;

    gpa_fhdo_seq_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (issue_c),
        .clear_i (clear_i),
        .din_i   (in_sample_c),
        .head_c  (head_c),
        .empty_c (fifo_empty_c),
        .full_c  (fifo_full_c),
        .count_o (fifo_count_o)
    );

    // Reload value is P-1 with P clamped to MIN_PERIOD.
    always_comb begin
        tick_c     = (cnt_q == '0);
        reload_c   = (period_i < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD - 1)
                                                        : period_i - PERIOD_W'(1);
        cnt_next_c = tick_c ? reload_c : cnt_q - PERIOD_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        underrun_d = underrun_q;
        late_d     = late_q;
        issue_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = STOP_ST;
                end else begin
                    cnt_d = cnt_next_c;
                    if (tick_c) begin
                        if (fifo_empty_c) begin
                            underrun_d = 1'b1;
                        end else if (bus.busy_i) begin
                            late_d  = 1'b1;
                            state_d = ST_PEND;
                        end else begin
                            issue_c = 1'b1;
                        end
                    end
                end
            end
            ST_PEND: begin
                if (stop_i) begin
                    state_d = STOP_ST;
                end else begin
                    cnt_d = cnt_next_c;
                    // A flush while pending leaves nothing to deliver.
                    if (fifo_empty_c) begin
                        state_d = ST_RUN;
                        if (tick_c) underrun_d = 1'b1;
                    end else if (!bus.busy_i) begin
                        issue_c = 1'b1;
                        state_d = ST_RUN;
                    end else if (tick_c) begin
                        late_d = 1'b1;
                    end
                end
            end
`ifdef GPA_FHDO_SEQ_ZERO_ON_STOP_EN
            ST_ZERO: begin
                if (!bus.busy_i) begin
                    dout_d  = '0;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (issue_c) begin
            dout_d  = head_c;
            valid_d = 1'b1;
        end
        if (clear_i) begin
            underrun_d = 1'b0;
            late_d     = 1'b0;
        end
        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            running_q  <= 1'b0;
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            running_q  <= running_d;
            underrun_q <= underrun_d;
            late_q     <= late_d;
        end
    end

    assign bus.datax_o  = dout_q.x;
    assign bus.datay_o  = dout_q.y;
    assign bus.dataz_o  = dout_q.z;
    assign bus.dataz2_o = dout_q.z2;
    assign bus.valid_o  = valid_q;
    assign running_o    = running_q;
    assign underrun_o   = underrun_q;
    assign late_o       = late_q;

endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// Directed bench for gpa_fhdo_seq with an issue-order scoreboard.
module tb_gpa_fhdo_seq;
    import gpa_fhdo_seq_pkg::*;

    localparam int unsigned FIFO_AW  = 4;
    localparam int unsigned PERIOD_W = 16;
`ifdef GPA_FHDO_SEQ_ZERO_ON_STOP_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i, stop_i, clear_i;
    logic [PERIOD_W-1:0] period_i;
    logic                running_o, underrun_o, late_o;
    logic [FIFO_AW:0]    fifo_count_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [95:0] exp_q[$];
    logic        prev_valid = 1'b0;

    gpa_fhdo_seq_if bus();

    gpa_fhdo_seq #(.FIFO_AW(FIFO_AW), .PERIOD_W(PERIOD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .clear_i      (clear_i),
        .period_i     (period_i),
        .running_o    (running_o),
        .underrun_o   (underrun_o),
        .late_o       (late_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] x, input logic [23:0] y,
                        input logic [23:0] z, input logic [23:0] z2, input bit accept);
        bus.in_datax_i  = x;
        bus.in_datay_i  = y;
        bus.in_dataz_i  = z;
        bus.in_dataz2_i = z2;
        bus.in_valid_i  = 1'b1;
        if (accept) exp_q.push_back({x, y, z, z2});
        step(1);
        bus.in_valid_i  = 1'b0;
    endtask

    // Stop playout; with the zero-on-stop build one all-zero update follows.
    task automatic stop_run();
        stop_i = 1'b1;
        if (ZERO_EN) exp_q.push_back('0);
        step(1);
        stop_i = 1'b0;
        step(1);
        chk("stop_running", 96'(running_o), 96'(0));
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("clear_flags", 96'({underrun_o, late_o}), 96'(0));
        chk("clear_count", 96'(fifo_count_o), 96'(0));
    endtask

    // Scoreboard: every valid_o pulse consumes the oldest expected sample.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            chk("valid_spacing", 96'(prev_valid), 96'(0));
            chk("valid_vs_busy", 96'(bus.busy_i), 96'(0));
            chk("sb_has_entry", 96'(exp_q.size() > 0), 96'(1));
            if (exp_q.size() > 0)
                chk("issue_data", {bus.datax_o, bus.datay_o, bus.dataz_o, bus.dataz2_o},
                    exp_q.pop_front());
        end
        prev_valid = bus.valid_o;
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; period_i = '0;
        bus.in_valid_i = 1'b0; bus.busy_i = 1'b0;
        bus.in_datax_i = '0; bus.in_datay_i = '0; bus.in_dataz_i = '0; bus.in_dataz2_i = '0;
        step(3);
        chk("rst_ready", 96'(bus.in_ready_o), 96'(0));
        chk("rst_outs", 96'({bus.valid_o, running_o, underrun_o, late_o}), 96'(0));
        chk("rst_data", {bus.datax_o, bus.datay_o, bus.dataz_o, bus.dataz2_o}, 96'(0));
        chk("rst_count", 96'(fifo_count_o), 96'(0));
        rst = 1'b0;
        step(1);
        chk("post_rst_ready", 96'(bus.in_ready_o), 96'(1));

        // Basic playout at period 100 followed by an underrun.
        push(24'd1, 24'd2, 24'd3, 24'd4, 1'b1);
        push(24'd5, 24'd6, 24'd7, 24'd8, 1'b1);
        chk("t1_count2", 96'(fifo_count_o), 96'(2));
        period_i = 16'd100;
        start_i = 1'b1; step(1); start_i = 1'b0;
        chk("t1_running", 96'(running_o), 96'(1));
        step(1);
        chk("t1_valid_a", 96'(bus.valid_o), 96'(1));
        chk("t1_datax_a", 96'(bus.datax_o), 96'(1));
        chk("t1_count1", 96'(fifo_count_o), 96'(1));
        step(99);
        chk("t1_no_early", 96'(bus.valid_o), 96'(0));
        step(1);
        chk("t1_valid_b", 96'(bus.valid_o), 96'(1));
        chk("t1_datax_b", 96'(bus.datax_o), 96'(5));
        chk("t1_count0", 96'(fifo_count_o), 96'(0));
        step(99);
        chk("t1_no_underrun", 96'(underrun_o), 96'(0));
        step(1);
        chk("t1_underrun", 96'(underrun_o), 96'(1));
        stop_run();
        do_clear();

        // Period 0 and 1 both clamp to a two-cycle tick.
        for (int i = 0; i < 6; i++)
            push(24'(16 + i), 24'(32 + i), 24'(48 + i), 24'(64 + i), 1'b1);
        period_i = 16'd0;
        start_i = 1'b1; step(1); start_i = 1'b0;
        chk("t2_k1", 96'(bus.valid_o), 96'(0));
        for (int k = 2; k <= 12; k++) begin
            step(1);
            chk("t2_tick2", 96'(bus.valid_o), 96'(k % 2 == 0));
            if (k == 8) period_i = 16'd1;
        end
        step(2);
        chk("t2_underrun", 96'(underrun_o), 96'(1));
        stop_run();
        do_clear();

        // Late update: busy straddles a tick, schedule unaffected.
        push(24'hA1, 24'hA2, 24'hA3, 24'hA4, 1'b1);
        push(24'hB1, 24'hB2, 24'hB3, 24'hB4, 1'b1);
        push(24'hC1, 24'hC2, 24'hC3, 24'hC4, 1'b1);
        period_i = 16'd10;
        start_i = 1'b1; step(1); start_i = 1'b0;
        step(1);
        chk("t3_valid_a", 96'(bus.valid_o), 96'(1));
        step(8);
        bus.busy_i = 1'b1;
        step(2);
        chk("t3_late", 96'(late_o), 96'(1));
        chk("t3_held", 96'(bus.valid_o), 96'(0));
        step(5);
        bus.busy_i = 1'b0;
        chk("t3_wait_busy", 96'(bus.valid_o), 96'(0));
        step(1);
        chk("t3_valid_b", 96'(bus.valid_o), 96'(1));
        step(3);
        chk("t3_gap", 96'(bus.valid_o), 96'(0));
        step(1);
        chk("t3_valid_c", 96'(bus.valid_o), 96'(1));
        chk("t3_late_sticky", 96'(late_o), 96'(1));
        stop_run();
        do_clear();

        // Fill to depth, overflow push dropped, drain in order.
        for (int i = 1; i <= 16; i++)
            push(24'(i), 24'(i + 100), 24'(i + 200), 24'(i + 300), 1'b1);
        chk("t4_full_ready", 96'(bus.in_ready_o), 96'(0));
        chk("t4_count16", 96'(fifo_count_o), 96'(16));
        push(24'd17, 24'd117, 24'd217, 24'd317, 1'b0);
        chk("t4_drop17", 96'(fifo_count_o), 96'(16));
        period_i = 16'd2;
        start_i = 1'b1; step(1); start_i = 1'b0;
        step(40);
        chk("t4_drained", 96'(fifo_count_o), 96'(0));
        chk("t4_sb_empty", 96'(exp_q.size()), 96'(0));
        stop_run();
        do_clear();
        chk("t4_ready_again", 96'(bus.in_ready_o), 96'(1));

        // Start with stop in IDLE; reset while pending.
        start_i = 1'b1; stop_i = 1'b1; step(1); start_i = 1'b0; stop_i = 1'b0;
        chk("t5_stop_prio", 96'(running_o), 96'(0));
        step(2);
        chk("t5_idle_quiet", 96'({running_o, bus.valid_o}), 96'(0));
        bus.busy_i = 1'b1;
        push(24'h11, 24'h12, 24'h13, 24'h14, 1'b1);
        push(24'h21, 24'h22, 24'h23, 24'h24, 1'b1);
        period_i = 16'd10;
        start_i = 1'b1; step(1); start_i = 1'b0;
        step(1);
        chk("t5_pend_late", 96'({late_o, running_o}), 96'(3));
        rst = 1'b1;
        step(1);
        chk("t5_rst_outs", 96'({bus.valid_o, running_o, underrun_o, late_o, bus.in_ready_o}), 96'(0));
        chk("t5_rst_count", 96'(fifo_count_o), 96'(0));
        chk("t5_rst_data", {bus.datax_o, bus.datay_o, bus.dataz_o, bus.dataz2_o}, 96'(0));
        exp_q.delete();
        rst = 1'b0;
        bus.busy_i = 1'b0;
        step(1);
        chk("t5_ready_after", 96'(bus.in_ready_o), 96'(1));

        // Stop after sample 9s: zero update only in the zero-on-stop build.
        period_i = 16'd4;
        push(24'd9, 24'd9, 24'd9, 24'd9, 1'b1);
        start_i = 1'b1; step(1); start_i = 1'b0;
        step(1);
        chk("t6_valid9", 96'(bus.valid_o), 96'(1));
        chk("t6_data9", 96'(bus.datax_o), 96'(9));
        stop_i = 1'b1;
        if (ZERO_EN) exp_q.push_back('0);
        step(1);
        stop_i = 1'b0;
        chk("t6_running_stop", 96'(running_o), 96'(ZERO_EN));
        step(1);
        chk("t6_zero_pulse", 96'(bus.valid_o), 96'(ZERO_EN));
        chk("t6_running_end", 96'(running_o), 96'(0));
        chk("t6_data_after", 96'(bus.datax_o), ZERO_EN ? 96'(0) : 96'(9));
        step(5);
        chk("t6_quiet", 96'({bus.valid_o, running_o}), 96'(0));
        chk("t6_hold", 96'(bus.dataz2_o), ZERO_EN ? 96'(0) : 96'(9));

        step(2);
        chk("final_sb_empty", 96'(exp_q.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpa_fhdo_seq.md
Name: gpa_fhdo_seq

Overview:
- Update scheduler placed in front of gpa_fhdo_iface.
- Buffers 4-channel gradient samples (x, y, z, z2; 24 bits each) in a small FIFO.
- Issues one sample to the interface every period_i clock cycles, and only while the interface is not busy.
- Flags underruns (no data at a tick) and late updates (interface still busy at a tick).

Parameters:
- FIFO_AW, 4, log2 of FIFO depth in samples (depth 16).
- PERIOD_W, 16, width of the update-period input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_datax_i, in_datay_i, in_dataz_i, in_dataz2_i  in  24 each  sample to enqueue
- in_valid_i  in  1  enqueue strobe
- in_ready_o  out  1  FIFO not full
- start_i  in  1  begin periodic playout
- stop_i  in  1  end playout
- clear_i  in  1  flush FIFO and clear sticky flags
- period_i  in  PERIOD_W  update period in clk cycles
- busy_i  in  1  busy_o from gpa_fhdo_iface
- datax_o, datay_o, dataz_o, dataz2_o  out  24 each  to iface datax_i, datay_i, dataz_i, dataz2_i
- valid_o  out  1  one-cycle strobe to iface valid_i
- running_o  out  1  high in any non-IDLE state
- underrun_o  out  1  sticky: a tick found the FIFO empty
- late_o  out  1  sticky: a tick found busy_i high
- fifo_count_o  out  FIFO_AW+1  current occupancy

Behaviour:
- Reset (rst high at a clk edge) forces all of the following; it may occur mid-transfer:
  - all outputs 0, including in_ready_o while rst is high;
  - FIFO empty, state IDLE, period counter 0.
  - in_ready_o rises on the first cycle after reset.
- Enqueue:
  - A push happens when in_valid_i && in_ready_o.
  - in_ready_o = (count < 2^FIFO_AW), from the registered count.
  - A push while full is ignored and the data is lost.
  - Push and pop in the same cycle: count is unchanged.
- Effective period P = max(period_i, 2). period_i is sampled at every counter reload, so changes take effect at the next reload.
- State machine:
  - IDLE:
    - start_i && !stop_i → RUN, counter loaded with 0 so the first tick is the next cycle.
    - stop_i has priority over start_i.
  - RUN:
    - Counter decrements each cycle. At 0 a tick occurs and the counter reloads P−1.
    - Tick, FIFO empty → set underrun_o; stay in RUN.
    - Tick, FIFO non-empty, busy_i low → issue.
    - Tick, FIFO non-empty, busy_i high → set late_o; go to PEND.
  - PEND:
    - Counter keeps running.
    - On the first cycle busy_i is low → issue; return to RUN.
    - A tick arriving while in PEND re-sets late_o only. No sample is skipped.
  - stop_i in RUN or PEND → IDLE on the next edge. A pending sample stays in the FIFO.
- Issue:
  - Data outputs register the FIFO head, valid_o=1 for exactly one cycle, and the FIFO pops in the same cycle.
  - Data outputs hold their last value between issues.
  - Latency from tick (or busy_i fall) to valid_o is 1 cycle.
- clear_i:
  - Empties the FIFO and clears underrun_o and late_o next cycle; state is unaffected.
  - clear_i coinciding with a push drops the push.
  - clear_i coinciding with an issue: the issue completes with the head data, then the FIFO is empty.
- valid_o is never asserted while busy_i is high in the same cycle.
- Pointers wrap modulo 2^FIFO_AW; count uses FIFO_AW+1 bits.

Optional Feature:
- Macro: GPA_FHDO_SEQ_ZERO_ON_STOP_EN.
- Enabled:
  - stop_i from RUN or PEND goes to state ZERO.
  - ZERO waits for busy_i low, then issues all channels = 24'h0 with one valid_o pulse, then goes to IDLE.
  - running_o stays high until that pulse.
  - rst aborts ZERO.
  - stop_i from IDLE does nothing.
- Disabled: the ZERO state is absent; stop_i goes straight to IDLE and the outputs keep their last values.

Decomposition:
- Package gpa_fhdo_seq_pkg holds:
  - state encoding (IDLE, RUN, PEND, ZERO);
  - CH_W=24;
  - MIN_PERIOD=2;
  - a sample type of 4×CH_W.
- Sub-module gpa_fhdo_seq_fifo: synchronous FIFO, 96 bits wide, depth 2^FIFO_AW, with push/pop/clear/count.

Test Plan:
- Push samples (1,2,3,4), (5,6,7,8); period_i=100; start_i; busy_i tied 0 → valid_o at cycles +1 and +101 after start with those values; fifo_count_o 2→1→0; underrun_o set at cycle +201.
- period_i=0 and 1 → ticks every 2 cycles; no valid_o on back-to-back cycles.
- busy_i high from tick−1 to tick+5 → late_o=1; valid_o one cycle after busy_i falls; next tick still on the original schedule.
- Push 17 samples with no pop → in_ready_o=0 after 16; fifo_count_o=16; 17th dropped; playout returns samples 1..16 in order.
- stop_i and start_i in the same cycle while in IDLE → stays IDLE. rst asserted during PEND → all outputs 0, FIFO empty next cycle.
- With GPA_FHDO_SEQ_ZERO_ON_STOP_EN, stop_i after sample (9,9,9,9) → one valid_o with all channels 0, then running_o=0. Without the macro → no extra pulse; outputs stay 9.
